// File: rtl/lpddr2_avl_responder.sv
// lpddr2_avl_responder: Avalon-MM LPDDR2 controller stand-in with init delay, per-command stall and fixed read latency
module lpddr2_avl_responder #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 32,
  parameter int MEM_AW      = 10,
  parameter int INIT_CYCLES = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int RD_LAT      = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  output logic              local_init_done,
  output logic              avl_waitrequest_n,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic [DATA_W-1:0] avl_writedata,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic              avl_burstbegin,
  output logic              avl_readdatavalid,
  output logic [DATA_W-1:0] avl_readdata,
  output logic              proto_err,
  output logic [15:0]       cmd_count
);
  typedef enum logic [1:0] {INIT, READY, STALL, ACCEPT} state_t;
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);
  state_t state;
  logic [15:0] cnt;
  logic cmd, rd_en, wr_en, unused;
  logic [MEM_AW-1:0] idx;
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [DATA_W-1:0] pd [RD_LAT];
  logic [RD_LAT-1:0] vld;
  always_comb begin
    cmd    = avl_read | avl_write;
    rd_en  = state == ACCEPT && avl_read;
    wr_en  = state == ACCEPT && avl_write && !avl_read;
    idx    = avl_address[MEM_AW-1:0];
    unused = ^{avl_burstbegin, avl_address[ADDR_W-1:MEM_AW]};
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state             <= INIT;
      cnt               <= '0;
      local_init_done   <= 1'b0;
      avl_waitrequest_n <= 1'b0;
      proto_err         <= 1'b0;
      cmd_count         <= '0;
    end else begin
      case (state)
        INIT:
          if (cnt == INIT_LAST) begin
            state           <= READY;
            local_init_done <= 1'b1;
          end else cnt <= cnt + 16'd1;
        READY:
          if (cmd) begin
            cnt               <= '0;
            state             <= WAIT_CYCLES == 0 ? ACCEPT : STALL;
            avl_waitrequest_n <= WAIT_CYCLES == 0;
          end
        STALL:
          if (!cmd) state <= READY;
          else if (cnt == WAIT_LAST) begin
            state             <= ACCEPT;
            avl_waitrequest_n <= 1'b1;
          end else cnt <= cnt + 16'd1;
        ACCEPT: begin
          state             <= READY;
          avl_waitrequest_n <= 1'b0;
          if (cmd) cmd_count <= cmd_count + 16'd1;
          if (avl_read && avl_write) proto_err <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end
  always_ff @(posedge iCLK) begin
    if (wr_en) mem[idx] <= avl_writedata;
    pd[0] <= mem[idx];
    for (int i = 1; i < RD_LAT; i++) pd[i] <= pd[i-1];
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      vld               <= '0;
      avl_readdatavalid <= 1'b0;
      avl_readdata      <= '0;
    end else begin
      vld               <= RD_LAT'({vld, rd_en});
      avl_readdatavalid <= vld[RD_LAT-1];
      if (vld[RD_LAT-1]) avl_readdata <= pd[RD_LAT-1];
    end
  end
endmodule

// File: tb/tb_lpddr2_avl_responder.sv
// tb_lpddr2_avl_responder: scoreboard bench for the Avalon LPDDR2 responder
module tb_lpddr2_avl_responder;
  localparam int RD_LAT = 4;
  typedef struct {logic [31:0] data; int cyc;} exp_t;
  logic iCLK = 1'b0, iRST = 1'b1;
  logic local_init_done, avl_waitrequest_n, avl_readdatavalid, proto_err;
  logic [26:0] avl_address = '0;
  logic [31:0] avl_writedata = '0, avl_readdata;
  logic avl_read = 1'b0, avl_write = 1'b0, avl_burstbegin = 1'b0;
  logic [15:0] cmd_count;
  int checks = 0, failures = 0, cyc = 0, exp_cnt = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] mem_m [1024];
  logic [31:0] last_exp = '0;
  lpddr2_avl_responder #(.RD_LAT(RD_LAT)) dut (
    .iCLK(iCLK), .iRST(iRST), .local_init_done(local_init_done),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address),
    .avl_writedata(avl_writedata), .avl_read(avl_read), .avl_write(avl_write),
    .avl_burstbegin(avl_burstbegin), .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata), .proto_err(proto_err), .cmd_count(cmd_count)
  );
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;
  always @(negedge iCLK) begin
    if (!iRST) begin
      checks++;
      if (avl_readdatavalid) begin
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected: readdatavalid with nothing pending, data=%h cyc=%0d", avl_readdata, cyc);
        end else begin
          e = q.pop_front();
          last_exp = e.data;
          if (avl_readdata !== e.data || cyc !== e.cyc) begin
            failures++;
            $display("FAIL rd_return: got data=%h cyc=%0d, expected data=%h cyc=%0d", avl_readdata, cyc, e.data, e.cyc);
          end
        end
      end else if (avl_readdata !== last_exp) begin
        failures++;
        $display("FAIL rd_hold: readdata=%h, expected held %h", avl_readdata, last_exp);
      end
    end
  end
  task automatic do_cmd(input logic rd, input logic wr, input logic [26:0] a, input logic [31:0] d, output int lat);
    int start;
    bit ok;
    ok = 0;
    lat = -1;
    @(posedge iCLK); #1;
    avl_read = rd; avl_write = wr; avl_address = a; avl_writedata = d; avl_burstbegin = 1'b1;
    start = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      if (avl_waitrequest_n) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: waitrequest_n stayed 0, expected acceptance");
    end else begin
      lat = cyc - start;
      exp_cnt++;
      if (rd) q.push_back('{mem_m[a[9:0]], cyc + 1 + RD_LAT});
      else if (wr) mem_m[a[9:0]] = d;
    end
    @(posedge iCLK); #1;
    avl_read = 1'b0; avl_write = 1'b0; avl_burstbegin = 1'b0;
    checks++;
    if (avl_waitrequest_n !== 1'b0) begin
      failures++;
      $display("FAIL accept_width: waitrequest_n=%b after accept, expected 0", avl_waitrequest_n);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge iCLK);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d reads outstanding, expected 0", q.size());
    end
    @(negedge iCLK);
  endtask
  task automatic check_cnt(input string name);
    checks++;
    if (cmd_count !== 16'(exp_cnt)) begin
      failures++;
      $display("FAIL %s: cmd_count=%0d, expected %0d", name, cmd_count, exp_cnt);
    end
  endtask
  task automatic check_reset_outputs(input string name);
    checks++;
    if ({local_init_done, avl_waitrequest_n, avl_readdatavalid, proto_err} !== 4'b0 || avl_readdata !== '0 || cmd_count !== '0) begin
      failures++;
      $display("FAIL %s: done=%b wrn=%b vld=%b perr=%b rdata=%h cnt=%0d, expected all 0",
               name, local_init_done, avl_waitrequest_n, avl_readdatavalid, proto_err, avl_readdata, cmd_count);
    end
  endtask
  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) @(negedge iCLK);
    check_reset_outputs("reset_values");
  endtask
  task automatic test_init();
    @(negedge iCLK);
    iRST = 1'b0;
    avl_address = 27'd5;
    for (int k = 1; k <= 16; k++) begin
      @(posedge iCLK); #1;
      if (k == 2) avl_read = 1'b1;
      checks++;
      if (local_init_done !== (k == 16) || avl_waitrequest_n !== 1'b0) begin
        failures++;
        $display("FAIL init_cycle%0d: done=%b wrn=%b, expected done=%b wrn=0", k, local_init_done, avl_waitrequest_n, k == 16);
      end
    end
    @(posedge iCLK); #1;
    avl_read = 1'b0;
    repeat (6) begin
      @(negedge iCLK);
      checks++;
      if (avl_waitrequest_n !== 1'b0 || local_init_done !== 1'b1) begin
        failures++;
        $display("FAIL withdraw: wrn=%b done=%b, expected wrn=0 done=1", avl_waitrequest_n, local_init_done);
      end
    end
    check_cnt("withdraw_count");
  endtask
  task automatic test_write();
    int lat;
    do_cmd(1'b0, 1'b1, 27'd5, 32'hDEADBEEF, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL write_latency: waitrequest_n after %0d cycles, expected 3", lat);
    end
    check_cnt("write_count");
  endtask
  task automatic test_read_alias();
    int lat;
    do_cmd(1'b1, 1'b0, 27'd5, 32'h0, lat);
    do_cmd(1'b1, 1'b0, 27'd5 + 27'd1024, 32'h0, lat);
    drain();
    check_cnt("read_count");
  endtask
  task automatic test_back_to_back();
    int lat;
    do_cmd(1'b0, 1'b1, 27'd7, 32'h11, lat);
    do_cmd(1'b1, 1'b0, 27'd7, 32'h0, lat);
    do_cmd(1'b0, 1'b1, 27'd7, 32'h22, lat);
    drain();
    do_cmd(1'b1, 1'b0, 27'd7, 32'h0, lat);
    drain();
    check_cnt("raw_count");
  endtask
  task automatic test_proto();
    int lat;
    do_cmd(1'b0, 1'b1, 27'd9, 32'h33, lat);
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL proto_pre: proto_err=%b, expected 0", proto_err);
    end
    do_cmd(1'b1, 1'b1, 27'd9, 32'h55, lat);
    drain();
    do_cmd(1'b1, 1'b0, 27'd9, 32'h0, lat);
    drain();
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_sticky: proto_err=%b, expected 1", proto_err);
    end
    check_cnt("proto_count");
  endtask
  task automatic test_reset_in_flight();
    int lat;
    bit ok;
    ok = 0;
    do_cmd(1'b1, 1'b0, 27'd5, 32'h0, lat);
    @(posedge iCLK); #1;
    iRST = 1'b1;
    q.delete();
    last_exp = '0;
    exp_cnt = 0;
    #1;
    check_reset_outputs("reset_async");
    repeat (6) begin
      @(negedge iCLK);
      checks++;
      if (avl_readdatavalid !== 1'b0) begin
        failures++;
        $display("FAIL reset_flush: readdatavalid=%b during reset, expected 0", avl_readdatavalid);
      end
    end
    check_reset_outputs("reset_hold");
    iRST = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      if (local_init_done) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reinit_timeout: local_init_done=0, expected 1");
    end
    do_cmd(1'b1, 1'b0, 27'd5, 32'h0, lat);
    drain();
    check_cnt("reinit_count");
  endtask
  initial begin
    test_reset();
    test_init();
    test_write();
    test_read_alias();
    test_back_to_back();
    test_proto();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
